barrel_shift_arbiter: RTL

//  Shares one RightBarrelShifter between two requesters (R0, R1) behind valid/ready handshakes.

---
 rtl/shift_pkg.sv | 36 +++
 rtl/RightBarrelShifter.sv | 35 +++
 rtl/barrel_shift_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared types for the shift arbiter: op encodings, FSM states and a bit-reverse helper.
// The ROT state exists only when SHIFT_ROTATE_EN is defined.
package shift_pkg;

  localparam int unsigned OP_W      = 2;
  localparam int unsigned REV_MAX_W = 64;
  localparam int unsigned REV_IDX_W = 6;

  typedef enum logic [OP_W-1:0] {
    OP_SRL = 2'b00,
    OP_SRA = 2'b01,
    OP_SLL = 2'b10,
    OP_ROR = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
`ifdef SHIFT_ROTATE_EN
    ROT  = 2'd2,
`endif
    DONE = 2'd3
  } arb_state_e;

  // Reverses the low n bits of x; bits at and above n come back as zero.
  function automatic logic [REV_MAX_W-1:0] bit_rev(input logic [REV_MAX_W-1:0] x,
                                                   input int unsigned n);
    logic [REV_MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < REV_MAX_W; i++) begin
      if (i < n) r[REV_IDX_W'(i)] = x[REV_IDX_W'(n - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/RightBarrelShifter.sv
// Combinational right shifter (logical or arithmetic).
// IMPL=0 uses the shift operator; IMPL=1 builds an explicit log2(width)-stage mux chain.
module RightBarrelShifter #(
  parameter int unsigned IMPL  = 1,
  parameter int unsigned width = 32
) (
  input  logic [width-1:0]         a,
  input  logic [$clog2(width)-1:0] w,
  input  logic                     arith,
  output logic [width-1:0]         y_c
);

  localparam int unsigned LW = $clog2(width);

  if (IMPL == 0) begin : g_behav
    always_comb begin
      y_c = arith ? $unsigned($signed(a) >>> w) : (a >> w);
    end
  end else begin : g_log
    logic             fill;
    logic [width-1:0] stage [LW+1];

    assign fill     = arith & a[width-1];
    assign stage[0] = a;

    // Stage k shifts by 2**k when amount bit k is set.
    for (genvar k = 0; k < LW; k++) begin : g_stage
      localparam int unsigned S = 1 << k;
      assign stage[k+1] = w[k] ? {{S{fill}}, stage[k][width-1:S]} : stage[k];
    end

    assign y_c = stage[LW];
  end

endmodule

// File: rtl/barrel_shift_arbiter.sv
// Round-robin front end sharing one RightBarrelShifter between two requesters.
// Define SHIFT_ROTATE_EN to make OP=11 a rotate-right (extra ROT pass); otherwise it runs as SRL.
module barrel_shift_arbiter
  import shift_pkg::*;
#(
  parameter int unsigned width = 32,
  parameter int unsigned IMPL  = 1
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     R0_VALID,
  output logic                     R0_READY,
  input  logic [OP_W-1:0]          R0_OP,
  input  logic [$clog2(width)-1:0] R0_W,
  input  logic [width-1:0]         R0_A,
  input  logic                     R1_VALID,
  output logic                     R1_READY,
  input  logic [OP_W-1:0]          R1_OP,
  input  logic [$clog2(width)-1:0] R1_W,
  input  logic [width-1:0]         R1_A,
  output logic                     RSP_VALID,
  input  logic                     RSP_READY,
  output logic                     RSP_TAG,
  output logic [width-1:0]         RSP_Y
);

  localparam int unsigned W_W = $clog2(width);

  arb_state_e       state_q, state_d;
  logic             last_q, last_d;
  shift_op_e        op_q, op_d;
  logic [W_W-1:0]   w_q, w_d;
  logic [width-1:0] a_q, a_d;
  logic             tag_q, tag_d;
  logic [width-1:0] y_q, y_d;
  logic             valid_q, valid_d;

  logic             gnt_vld;
  logic             gnt_idx;
  logic             idle;
  logic             rot_pass;
  logic             rev_in;
  logic [width-1:0] sh_a;
  logic [W_W-1:0]   sh_w;
  logic             sh_arith;
  logic [width-1:0] sh_y;
  logic [width-1:0] res;

  // On contention, grant the requester that did not win last time.
  always_comb begin
    gnt_vld = R0_VALID | R1_VALID;
    gnt_idx = 1'b0;
    if (R0_VALID && R1_VALID) gnt_idx = ~last_q;
    else if (R1_VALID)        gnt_idx = 1'b1;
  end

  assign idle     = (state_q == IDLE);
  assign R0_READY = RST_N & idle & R0_VALID & ~gnt_idx;
  assign R1_READY = RST_N & idle & R1_VALID &  gnt_idx;

`ifdef SHIFT_ROTATE_EN
  assign rot_pass = (state_q == ROT);
`else
  assign rot_pass = 1'b0;
`endif

  // Left shifts (and the rotate's second pass) run the right shifter on reversed data.
  assign rev_in   = (op_q == OP_SLL) || rot_pass;
  assign sh_a     = rev_in ? width'(bit_rev(REV_MAX_W'(a_q), width)) : a_q;
  assign sh_w     = rot_pass ? ((~w_q) + W_W'(1)) : w_q;
  assign sh_arith = (op_q == OP_SRA) && !rot_pass;
  assign res      = rev_in ? width'(bit_rev(REV_MAX_W'(sh_y), width)) : sh_y;

  RightBarrelShifter #(
    .IMPL  (IMPL),
    .width (width)
  ) u_shifter (
    .a     (sh_a),
    .w     (sh_w),
    .arith (sh_arith),
    .y_c   (sh_y)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    op_d    = op_q;
    w_d     = w_q;
    a_d     = a_q;
    tag_d   = tag_q;
    y_d     = y_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          op_d    = shift_op_e'(gnt_idx ? R1_OP : R0_OP);
          w_d     = gnt_idx ? R1_W : R0_W;
          a_d     = gnt_idx ? R1_A : R0_A;
          tag_d   = gnt_idx;
          last_d  = gnt_idx;
          state_d = EXEC;
        end
      end
      EXEC: begin
        y_d = res;
`ifdef SHIFT_ROTATE_EN
        if (op_q == OP_ROR && w_q != '0) state_d = ROT;
        else                             state_d = DONE;
`else
        state_d = DONE;
`endif
      end
`ifdef SHIFT_ROTATE_EN
      ROT: begin
        y_d     = y_q | res;
        state_d = DONE;
      end
`endif
      DONE: begin
        // Valid rises one cycle into DONE and drops on the response handshake.
        valid_d = 1'b1;
        if (valid_q && RSP_READY) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      op_q    <= OP_SRL;
      w_q     <= '0;
      a_q     <= '0;
      tag_q   <= 1'b0;
      y_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      op_q    <= op_d;
      w_q     <= w_d;
      a_q     <= a_d;
      tag_q   <= tag_d;
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  end

  assign RSP_VALID = valid_q;
  assign RSP_TAG   = tag_q;
  assign RSP_Y     = y_q;

endmodule
